// File: rtl/move_scheduler_pkg.sv
// Shared game definitions: direction codes, scheduler state encoding and
// small helpers used by the move scheduler and the position tracker.
package move_scheduler_pkg;

    localparam logic [3:0] KEY_UP    = 4'h2;
    localparam logic [3:0] KEY_LEFT  = 4'h4;
    localparam logic [3:0] KEY_RIGHT = 4'h6;
    localparam logic [3:0] KEY_DOWN  = 4'h8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_COOLDOWN = 3'd3,
        ST_RELEASE  = 3'd4
    } sched_state_e;

    // True only for the four direction codes.
    function automatic logic key_is_legal(input logic [3:0] key);
        logic legal;
        case (key)
            KEY_UP, KEY_LEFT, KEY_RIGHT, KEY_DOWN: legal = 1'b1;
            default:                               legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic int unsigned max_cycles(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/move_scheduler_stable_counter.sv
// Saturating up-counter shared by the debounce, cooldown and release phases.
// tc is high once the count has reached the terminal value supplied by the
// current phase; the count never moves past it.
module stable_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_50MHz_i,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] terminal,
    output logic             tc
);

    logic [WIDTH-1:0] count_r;

    assign tc = (count_r >= terminal);

    // Count enabled cycles, clear on request, hold at the terminal count.
    always_ff @(posedge clk_50MHz_i or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {WIDTH{1'b0}};
        end else if (clr) begin
            count_r <= {WIDTH{1'b0}};
        end else if (en && !tc) begin
            count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/move_scheduler.sv
// Move scheduler: debounces the keypad, arbitrates against the scripted
// requester (keypad wins), issues one move strobe per accepted request and
// enforces a cooldown plus a keypad-release phase (no auto-repeat).
module move_scheduler
    import move_scheduler_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned COOLDOWN_CYCLES = 2500000
) (
    input  logic       clk_50MHz_i,
    input  logic       rst_async_la_i,
    input  logic [3:0] kp_key_i,
    input  logic       kp_valid_i,
    input  logic       demo_mode_i,
    input  logic       demo_req_i,
    input  logic [3:0] demo_key_i,
    output logic       demo_ack_o,
    output logic [3:0] key_o,
    output logic       enable_move_o,
    output logic       src_o,
    output logic       busy_o
);

    localparam int unsigned MAX_CYCLES = max_cycles(DEBOUNCE_CYCLES, COOLDOWN_CYCLES);
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    // Debounce/release end on the last of N stable cycles. The cooldown count
    // starts in the ISSUE cycle, so N cycles span ISSUE plus N-1 COOLDOWN cycles.
    localparam logic [CNT_W-1:0] DEB_TERM  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOL_TERM = CNT_W'(COOLDOWN_CYCLES - 1);

    logic [1:0]       rst_sync_r;
    logic             rst_n_s;
    sched_state_e     state_r, state_nxt_s;
    logic [3:0]       key_lat_r, key_lat_nxt_s;
    logic [3:0]       key_r, key_nxt_s;
    logic             src_r, src_nxt_s;
    logic             demo_ack_r, ack_nxt_s;
    logic             enable_r, busy_r;
    logic             cnt_clr_s, cnt_en_s, cnt_tc_s;
    logic [CNT_W-1:0] cnt_term_s;

    // Reset asserts immediately and releases two clock edges later.
    always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
        if (!rst_async_la_i) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_r[1];

    stable_counter #(
        .WIDTH (CNT_W)
    ) u_counter (
        .clk_50MHz_i (clk_50MHz_i),
        .rst_n       (rst_n_s),
        .clr         (cnt_clr_s),
        .en          (cnt_en_s),
        .terminal    (cnt_term_s),
        .tc          (cnt_tc_s)
    );

    // Next-state, latched-code and counter-control decode.
    always_comb begin
        state_nxt_s   = state_r;
        key_lat_nxt_s = key_lat_r;
        key_nxt_s     = key_r;
        src_nxt_s     = src_r;
        ack_nxt_s     = 1'b0;
        cnt_clr_s     = 1'b0;
        cnt_en_s      = 1'b0;
        cnt_term_s    = DEB_TERM;
        case (state_r)
            ST_IDLE: begin
                cnt_clr_s = 1'b1;
                if (kp_valid_i) begin
                    if (key_is_legal(kp_key_i)) begin
                        state_nxt_s   = ST_DEBOUNCE;
                        key_lat_nxt_s = kp_key_i;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else if (demo_mode_i && demo_req_i && !demo_ack_r) begin
                    // The ack of an illegal request is visible next cycle;
                    // demo_ack_r masks the still-held request meanwhile.
                    ack_nxt_s = 1'b1;
                    if (key_is_legal(demo_key_i)) begin
                        state_nxt_s   = ST_ISSUE;
                        key_lat_nxt_s = demo_key_i;
                        key_nxt_s     = demo_key_i;
                        src_nxt_s     = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DEBOUNCE: begin
                cnt_term_s = DEB_TERM;
                if (!kp_valid_i) begin
                    state_nxt_s = ST_IDLE;
                    cnt_clr_s   = 1'b1;
                end else if (kp_key_i != key_lat_r) begin
                    cnt_clr_s = 1'b1;
                    if (key_is_legal(kp_key_i)) begin
                        key_lat_nxt_s = kp_key_i;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else if (cnt_tc_s) begin
                    state_nxt_s = ST_ISSUE;
                    key_nxt_s   = key_lat_r;
                    src_nxt_s   = 1'b0;
                    cnt_clr_s   = 1'b1;
                end else begin
                    cnt_en_s = 1'b1;
                end
            end
            ST_ISSUE: begin
                cnt_term_s  = COOL_TERM;
                cnt_en_s    = 1'b1;
                state_nxt_s = ST_COOLDOWN;
            end
            ST_COOLDOWN: begin
                cnt_term_s = COOL_TERM;
                if (cnt_tc_s) begin
                    cnt_clr_s   = 1'b1;
                    state_nxt_s = src_r ? ST_IDLE : ST_RELEASE;
                end else begin
                    cnt_en_s = 1'b1;
                end
            end
            ST_RELEASE: begin
                cnt_term_s = DEB_TERM;
                if (kp_valid_i) begin
                    cnt_clr_s = 1'b1;
                end else if (cnt_tc_s) begin
                    cnt_clr_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_en_s = 1'b1;
                end
            end
            default: begin
                cnt_clr_s   = 1'b1;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, latched code and registered outputs.
    always_ff @(posedge clk_50MHz_i or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r    <= ST_IDLE;
            key_lat_r  <= 4'h0;
            key_r      <= 4'h0;
            src_r      <= 1'b0;
            demo_ack_r <= 1'b0;
            enable_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            key_lat_r  <= key_lat_nxt_s;
            key_r      <= key_nxt_s;
            src_r      <= src_nxt_s;
            demo_ack_r <= ack_nxt_s;
            enable_r   <= (state_nxt_s == ST_ISSUE);
            busy_r     <= (state_nxt_s != ST_IDLE);
        end
    end

    assign demo_ack_o    = demo_ack_r;
    assign key_o         = key_r;
    assign enable_move_o = enable_r;
    assign src_o         = src_r;
    assign busy_o        = busy_r;

endmodule

// File: tb/tb_move_scheduler.sv
// Directed self-checking bench for move_scheduler with short debounce and
// cooldown so every scenario fits in a few dozen cycles.
module tb_move_scheduler;

    logic       clk;
    logic       rst_n;
    logic [3:0] kp_key;
    logic       kp_valid;
    logic       demo_mode;
    logic       demo_req;
    logic [3:0] demo_key;
    logic       demo_ack;
    logic [3:0] key;
    logic       enable_move;
    logic       src;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    move_scheduler #(
        .DEBOUNCE_CYCLES (4),
        .COOLDOWN_CYCLES (8)
    ) dut (
        .clk_50MHz_i    (clk),
        .rst_async_la_i (rst_n),
        .kp_key_i       (kp_key),
        .kp_valid_i     (kp_valid),
        .demo_mode_i    (demo_mode),
        .demo_req_i     (demo_req),
        .demo_key_i     (demo_key),
        .demo_ack_o     (demo_ack),
        .key_o          (key),
        .enable_move_o  (enable_move),
        .src_o          (src),
        .busy_o         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and stop on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        repeat (2) tick();
        obs = {enable_move, demo_ack, src, busy, key};
        n_checks++;
        if (obs !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 00", obs);
        end
        // Release reset with a legal script request waiting: it is taken on
        // the first cycle after the two-stage synchroniser lets go.
        demo_mode = 1'b1;
        demo_req  = 1'b1;
        demo_key  = 4'h2;
        rst_n     = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_checks++;
            if (enable_move !== (i == 3)) begin
                n_fail++;
                $display("FAIL reset_release_strobe cycle %0d: got %b expected %b", i, enable_move, (i == 3));
            end
        end
        obs = {demo_ack, src, 2'b00, key};
        n_checks++;
        if (obs !== 8'hC2) begin
            n_fail++;
            $display("FAIL reset_release_issue: got %h expected c2", obs);
        end
        demo_req = 1'b0;
        repeat (8) tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %b expected 0", busy);
        end
        demo_mode = 1'b0;
    endtask

    task automatic test_single_press();
        kp_key   = 4'h6;
        kp_valid = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            n_checks++;
            if (enable_move !== (i == 5)) begin
                n_fail++;
                $display("FAIL press_strobe cycle %0d: got %b expected %b", i, enable_move, (i == 5));
            end
            if (i >= 5 && i <= 13) begin
                n_checks++;
                if (key !== 4'h6) begin
                    n_fail++;
                    $display("FAIL press_key cycle %0d: got %h expected 6", i, key);
                end
            end
            if (i == 5) begin
                n_checks++;
                if (src !== 1'b0) begin
                    n_fail++;
                    $display("FAIL press_src: got %b expected 0", src);
                end
            end
        end
        kp_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_checks++;
            if (busy !== (i < 4) || enable_move !== 1'b0) begin
                n_fail++;
                $display("FAIL release_phase cycle %0d: got busy %b strobe %b expected busy %b strobe 0", i, busy, enable_move, (i < 4));
            end
        end
    endtask

    task automatic test_glitch();
        logic [7:0] pat;
        pat    = 8'b0111_0111;
        kp_key = 4'h4;
        for (int k = 0; k < 8; k++) begin
            kp_valid = pat[k];
            tick();
            n_checks++;
            if (enable_move !== 1'b0 || busy !== pat[k]) begin
                n_fail++;
                $display("FAIL glitch step %0d: got strobe %b busy %b expected strobe 0 busy %b", k, enable_move, busy, pat[k]);
            end
        end
        kp_valid = 1'b0;
    endtask

    task automatic test_arbitration();
        kp_key    = 4'h2;
        kp_valid  = 1'b1;
        demo_mode = 1'b1;
        demo_req  = 1'b1;
        demo_key  = 4'h8;
        for (int i = 1; i <= 14; i++) begin
            tick();
            n_checks++;
            if (enable_move !== (i == 5) || demo_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL arb_keypad cycle %0d: got strobe %b ack %b expected strobe %b ack 0", i, enable_move, demo_ack, (i == 5));
            end
            if (i == 5) begin
                n_checks++;
                if ({src, key} !== 5'h02) begin
                    n_fail++;
                    $display("FAIL arb_grant: got src %b key %h expected src 0 key 2", src, key);
                end
            end
        end
        kp_valid = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            tick();
            n_checks++;
            if (enable_move !== (j == 5) || demo_ack !== (j == 5)) begin
                n_fail++;
                $display("FAIL arb_script cycle %0d: got strobe %b ack %b expected %b", j, enable_move, demo_ack, (j == 5));
            end
        end
        n_checks++;
        if ({src, key} !== 5'h18) begin
            n_fail++;
            $display("FAIL arb_script_key: got src %b key %h expected src 1 key 8", src, key);
        end
        demo_req = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_checks++;
            if (enable_move !== 1'b0) begin
                n_fail++;
                $display("FAIL arb_no_extra cycle %0d: got %b expected 0", i, enable_move);
            end
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL arb_idle: got %b expected 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        logic exp;
        demo_mode = 1'b1;
        demo_key  = 4'h8;
        demo_req  = 1'b1;
        for (int i = 1; i <= 28; i++) begin
            tick();
            exp = (i == 1) || (i == 10) || (i == 19);
            n_checks++;
            if (enable_move !== exp || demo_ack !== exp) begin
                n_fail++;
                $display("FAIL b2b cycle %0d: got strobe %b ack %b expected %b", i, enable_move, demo_ack, exp);
            end
            if (i == 19) demo_req = 1'b0;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: got %b expected 0", busy);
        end
    endtask

    task automatic test_illegal();
        demo_key = 4'h5;
        demo_req = 1'b1;
        tick();
        n_checks++;
        if ({demo_ack, enable_move, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL illegal_script: got ack/strobe/busy %b expected 100", {demo_ack, enable_move, busy});
        end
        demo_req = 1'b0;
        tick();
        n_checks++;
        if (demo_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_single_ack: got %b expected 0", demo_ack);
        end
        kp_key   = 4'h0;
        kp_valid = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_checks++;
            if (busy !== 1'b0 || enable_move !== 1'b0) begin
                n_fail++;
                $display("FAIL illegal_keypad cycle %0d: got busy %b strobe %b expected 0 0", i, busy, enable_move);
            end
        end
        kp_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] obs;
        demo_mode = 1'b1;
        demo_key  = 4'h8;
        demo_req  = 1'b1;
        tick();
        demo_req = 1'b0;
        repeat (2) tick();
        obs = {busy, src, 2'b00, key};
        n_checks++;
        if (obs !== 8'hC8) begin
            n_fail++;
            $display("FAIL midreset_pre: got %h expected c8", obs);
        end
        #2;
        rst_n = 1'b0;
        #1;
        obs = {enable_move, demo_ack, src, busy, key};
        n_checks++;
        if (obs !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %h expected 00", obs);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            n_checks++;
            if (enable_move !== 1'b0 || key !== 4'h0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_after cycle %0d: got strobe %b key %h busy %b expected 0 0 0", i, enable_move, key, busy);
            end
        end
        demo_mode = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        kp_key    = 4'h0;
        kp_valid  = 1'b0;
        demo_mode = 1'b0;
        demo_req  = 1'b0;
        demo_key  = 4'h0;
        test_reset();
        test_single_press();
        test_glitch();
        test_arbitration();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/move_scheduler.md
MOVE_SCHEDULER -- requirements
Module: move_scheduler

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz), number of stable cycles required to accept a keypad press or release.
REQ-002 Parameter COOLDOWN_CYCLES, default 2500000 (50 ms), minimum number of cycles between consecutive issued moves.
REQ-003 clk_50MHz_i  in  1  system clock, 50 MHz.
REQ-004 rst_async_la_i  in  1  reset, asynchronous, active-low.
REQ-005 kp_key_i  in  4  keypad code; 4'h2 up, 4'h4 left, 4'h6 right, 4'h8 down.
REQ-006 kp_valid_i  in  1  keypad key held (level).
REQ-007 demo_mode_i  in  1  enables the scripted requester.
REQ-008 demo_req_i  in  1  scripted move request (level, held until acked).
REQ-009 demo_key_i  in  4  scripted move code, same encoding as kp_key_i.
REQ-010 demo_ack_o  out  1  one-cycle pulse: scripted request consumed.
REQ-011 key_o  out  4  move code driven to the position tracker's key_in.
REQ-012 enable_move_o  out  1  one-cycle move strobe to the position tracker's enable_move.
REQ-013 src_o  out  1  source of the current or last move; 0 keypad, 1 script.
REQ-014 busy_o  out  1  high in every state except IDLE.

Function
REQ-015 FSM states: IDLE, DEBOUNCE, ISSUE, COOLDOWN, RELEASE; exactly one state per cycle.
REQ-016 Legal codes are 4'h2, 4'h4, 4'h6 and 4'h8 only; a request carrying any other code SHALL be ignored, and an illegal scripted request SHALL be acked with no strobe.
REQ-017 IDLE -> DEBOUNCE when kp_valid_i=1 with a legal code; latch the code and clear the counter.
REQ-018 IDLE -> ISSUE when kp_valid_i=0, demo_mode_i=1, demo_req_i=1 and the code is legal; latch demo_key_i and set src_o=1.
REQ-019 Arbitration is fixed priority, keypad first: a simultaneous keypad and script request in IDLE grants the keypad.
REQ-020 DEBOUNCE: kp_valid_i=0 -> IDLE; a code change restarts the count with the new code; DEBOUNCE_CYCLES consecutive equal cycles -> ISSUE with src_o=0.
REQ-021 ISSUE lasts 1 cycle: enable_move_o=1, key_o=latched code, and demo_ack_o=1 if src_o=1; -> COOLDOWN.
REQ-022 key_o SHALL be stable from the ISSUE cycle through the last COOLDOWN cycle, because the tracker samples the strobe one cycle late.
REQ-023 COOLDOWN counts COOLDOWN_CYCLES cycles, then goes to RELEASE if src_o=0, otherwise to IDLE.
REQ-024 RELEASE requires kp_valid_i=0 for DEBOUNCE_CYCLES consecutive cycles, then -> IDLE; any high cycle restarts the count, so there is no auto-repeat.
REQ-025 Exactly one enable_move_o pulse is produced per accepted press or per acked legal script request.
REQ-026 Deasserting demo_mode_i or demo_req_i after ISSUE SHALL NOT abort the in-flight move.
REQ-027 Counters are sized to max(DEBOUNCE_CYCLES, COOLDOWN_CYCLES) and saturate at the terminal count, never wrapping.
REQ-028 All outputs are registered.

Reset
REQ-029 Asserting rst_async_la_i low immediately forces: state=IDLE, counters=0, key_o=4'h0, enable_move_o=0, demo_ack_o=0, src_o=0, busy_o=0.
REQ-030 Reset mid-operation SHALL discard the latched code, and no strobe is issued after release.
REQ-031 Reset deassertion is synchronised to clk_50MHz_i, and the first request is accepted on the first cycle after synchronised release.

Structure
REQ-032 The direction-code constants (4'h2/4/6/8) and the FSM state encoding SHALL live in a shared game package, also used by the position tracker.
REQ-033 The debounce/cooldown counter is one sub-module, stable_counter (clear, enable, terminal-count flag), instantiated once and reused by DEBOUNCE, COOLDOWN and RELEASE.

Verification (DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=8)
REQ-034 kp_key_i=4'h6 with kp_valid_i=1 held 20 cycles -> exactly one enable_move_o pulse, 4 cycles after entering DEBOUNCE; key_o=4'h6 for 9 cycles; no second pulse.
REQ-035 kp_valid_i high 3 cycles, low 1 cycle, high 3 cycles -> no pulse, FSM back in IDLE.
REQ-036 Same-cycle keypad 4'h2 and script 4'h8 with demo_mode_i=1 -> keypad granted (src_o=0, key_o=4'h2); script acked after keypad release plus RELEASE.
REQ-037 demo_mode_i=1 with three back-to-back script requests 4'h8 -> three pulses spaced 9 cycles apart, three demo_ack_o pulses.
REQ-038 Script code 4'h5 -> demo_ack_o pulse with no enable_move_o; keypad 4'h0 held -> no state change.
REQ-039 rst_async_la_i pulsed low during COOLDOWN -> all outputs at reset values in the same cycle; no pulse after release.
